// File: rtl/flip_engine.sv
// flip_engine: Othello rules engine that owns the 8x8 board and streams every changed cell to the drawing stage.
// Optional macro COUNT_EN enables incremental black/white disk counters (tied to 0 when undefined).
module flip_engine #(
    parameter int FLIP_GAP = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       place_req,
    input  logic [2:0] place_col,
    input  logic [2:0] place_row,
    input  logic       side,
    output logic       busy,
    output logic       done,
    output logic       move_valid,
    output logic [5:0] flip_count,
    output logic       upd_valid,
    input  logic       upd_ready,
    output logic [2:0] upd_col,
    output logic [2:0] upd_row,
    output logic [1:0] upd_cell,
    input  logic [2:0] rd_col,
    input  logic [2:0] rd_row,
    output logic [1:0] rd_cell,
    output logic [6:0] black_count,
    output logic [6:0] white_count
);
    localparam int GW = $clog2(FLIP_GAP + 2);
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b10;

    typedef enum logic [2:0] {IDLE, CHECK, SCAN, FLIP, NEXT, PLACE, DONE} state_t;

    state_t        state;
    logic [1:0]    board [64];
    logic [2:0]    t_col, t_row, cur_col, cur_row, dir, k, left;
    logic          mover;
    logic [5:0]    total;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    dc, dr, nxt_col, nxt_row;
    logic          oob, xfer;
    logic [1:0]    own, opp, nxt_cell, tgt_cell;

    // Board index is row*8 + col.
    function automatic logic [1:0] reset_cell(input int idx);
        case (idx)
            27, 36:  return WHITE;
            28, 35:  return BLACK;
            default: return EMPTY;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        dc = 4'h0;
        dr = 4'h0;
        case (dir)
            3'd0: dr = 4'hF;
            3'd1: begin dc = 4'h1; dr = 4'hF; end
            3'd2: dc = 4'h1;
            3'd3: begin dc = 4'h1; dr = 4'h1; end
            3'd4: dr = 4'h1;
            3'd5: begin dc = 4'hF; dr = 4'h1; end
            3'd6: dc = 4'hF;
            default: begin dc = 4'hF; dr = 4'hF; end
        endcase
        nxt_col = {1'b0, cur_col} + dc;
        nxt_row = {1'b0, cur_row} + dr;
    end

    // Stepping off either edge lands on 8 or 15, both of which set bit 3.
    assign oob      = nxt_col[3] | nxt_row[3];
    assign nxt_cell = board[{nxt_row[2:0], nxt_col[2:0]}];
    assign tgt_cell = board[{t_row, t_col}];
    assign own      = mover ? WHITE : BLACK;
    assign opp      = mover ? BLACK : WHITE;
    assign xfer     = upd_valid && upd_ready;
    assign rd_cell  = board[{rd_row, rd_col}];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_valid <= 1'b0;
            flip_count <= '0;
            upd_valid  <= 1'b0;
            upd_col    <= '0;
            upd_row    <= '0;
            upd_cell   <= '0;
            t_col      <= '0;
            t_row      <= '0;
            cur_col    <= '0;
            cur_row    <= '0;
            dir        <= '0;
            k          <= '0;
            left       <= '0;
            mover      <= 1'b0;
            total      <= '0;
            gap_cnt    <= '0;
            // NOTE: the board is a register file with a defined opening position, so it is reset like any other state.
            for (int i = 0; i < 64; i++) board[i] <= reset_cell(i);
        end else begin
            // NOTE: non-blocking throughout; later assignments in the case below override these defaults.
            done <= 1'b0;
            if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
            if (xfer) board[{upd_row, upd_col}] <= upd_cell;

            case (state)
                IDLE: if (place_req) begin
                    t_col <= place_col;
                    t_row <= place_row;
                    mover <= side;
                    busy  <= 1'b1;
                    state <= CHECK;
                end
                CHECK: if (tgt_cell != EMPTY) begin
                    move_valid <= 1'b0;
                    flip_count <= '0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= DONE;
                end else begin
                    dir     <= '0;
                    total   <= '0;
                    k       <= '0;
                    cur_col <= t_col;
                    cur_row <= t_row;
                    state   <= SCAN;
                end
                SCAN: begin
                    if (oob || nxt_cell == EMPTY) begin
                        state <= NEXT;
                    end else if (nxt_cell == opp) begin
                        k       <= k + 3'd1;
                        cur_col <= nxt_col[2:0];
                        cur_row <= nxt_row[2:0];
                    end else if (k != 3'd0) begin
                        left    <= k;
                        cur_col <= t_col;
                        cur_row <= t_row;
                        state   <= FLIP;
                    end else begin
                        state <= NEXT;
                    end
                end
                FLIP: begin
                    if (upd_valid) begin
                        if (upd_ready) begin
                            total <= total + 6'd1;
                            left  <= left - 3'd1;
                            if (left == 3'd1) begin
                                upd_valid <= 1'b0;
                                gap_cnt   <= GW'(FLIP_GAP);
                                state     <= NEXT;
                            end else if (FLIP_GAP == 0) begin
                                // Back-to-back offer: cur already points at the cell just accepted.
                                upd_col <= nxt_col[2:0];
                                upd_row <= nxt_row[2:0];
                                cur_col <= nxt_col[2:0];
                                cur_row <= nxt_row[2:0];
                            end else begin
                                upd_valid <= 1'b0;
                                gap_cnt   <= GW'(FLIP_GAP);
                            end
                        end
                    end else if (gap_cnt <= GW'(1)) begin
                        upd_col   <= nxt_col[2:0];
                        upd_row   <= nxt_row[2:0];
                        upd_cell  <= own;
                        upd_valid <= 1'b1;
                        cur_col   <= nxt_col[2:0];
                        cur_row   <= nxt_row[2:0];
                    end
                end
                NEXT: begin
                    if (dir == 3'd7) begin
                        if (total != '0) begin
                            state <= PLACE;
                        end else begin
                            move_valid <= 1'b0;
                            flip_count <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end else begin
                        dir     <= dir + 3'd1;
                        k       <= '0;
                        cur_col <= t_col;
                        cur_row <= t_row;
                        state   <= SCAN;
                    end
                end
                PLACE: begin
                    if (upd_valid) begin
                        if (upd_ready) begin
                            upd_valid  <= 1'b0;
                            gap_cnt    <= GW'(FLIP_GAP);
                            move_valid <= 1'b1;
                            flip_count <= total;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end else if (gap_cnt <= GW'(1)) begin
                        upd_col   <= t_col;
                        upd_row   <= t_row;
                        upd_cell  <= own;
                        upd_valid <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COUNT_EN
    logic [6:0] b_cnt, w_cnt;

    // Every accepted update in FLIP converts one opponent disk; the PLACE update only adds one.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            b_cnt <= 7'd2;
            w_cnt <= 7'd2;
        end else if (xfer) begin
            if (mover) begin
                w_cnt <= w_cnt + 7'd1;
                if (state == FLIP) b_cnt <= b_cnt - 7'd1;
            end else begin
                b_cnt <= b_cnt + 7'd1;
                if (state == FLIP) w_cnt <= w_cnt - 7'd1;
            end
        end
    end

    assign black_count = b_cnt;
    assign white_count = w_cnt;
`else
    assign black_count = '0;
    assign white_count = '0;
`endif

endmodule

// File: doc/flip_engine.md
Name: flip_engine

Overview:
Othello rules engine that owns the 8x8 board state and sits directly upstream of the drawing datapath/plothelper stage.
- On a place request from the control FSM it checks legality, flips captured disks direction by direction, and writes the placed disk.
- Each changed cell is emitted as a ready/valid cell-update stream, which the drawing stage consumes to redraw that cell.
- It also provides a combinational read port for cursor rendering.

Parameters:
FLIP_GAP, 0, idle cycles inserted after each accepted update before the next is offered; used for flip animation pacing.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous reset, active-high (1 = reset); name matches the datapath/plothelper reset port
place_req  in  1  one-cycle request to place a disk; sampled only in IDLE
place_col  in  3  target column 0..7
place_row  in  3  target row 0..7
side  in  1  mover: 0 = black, 1 = white; sampled with place_req
busy  out  1  high from the cycle after an accepted place_req until done
done  out  1  one-cycle pulse when a request completes
move_valid  out  1  result of the last request; valid while done is high and held until the next done
flip_count  out  6  disks flipped by the last request; held until the next done
upd_valid  out  1  cell-update offer
upd_ready  in  1  drawing stage accepts the update
upd_col  out  3  column of the updated cell
upd_row  out  3  row of the updated cell
upd_cell  out  2  new contents: 00 empty, 01 black, 10 white
rd_col  in  3  read-port column
rd_row  in  3  read-port row
rd_cell  out  2  combinational contents of (rd_col, rd_row)
black_count  out  7  disks of black on the board (COUNT_EN only)
white_count  out  7  disks of white on the board (COUNT_EN only)

Behaviour:
- Board storage: 64 x 2-bit registers.
- Reset value of the board: (3,3) = white, (4,4) = white, (3,4) = black, (4,3) = black; all other cells empty. Coordinates are (col,row).
- Reset values of outputs: busy, done, move_valid, upd_valid = 0; flip_count = 0; upd_col, upd_row, upd_cell = 0; black_count = 2, white_count = 2.
- Reset asserted mid-operation aborts immediately to IDLE with the reset board. A pending update is dropped.
- States:
  - IDLE: on place_req, latch col, row and side, then go to CHECK. place_req in any other state is ignored, with no queueing.
  - CHECK: target not empty -> move_valid = 0, flip_count = 0, go to DONE. Otherwise set dir = 0 and total = 0, go to SCAN.
  - SCAN: direction order 0 N(row-1), 1 NE, 2 E, 3 SE, 4 S, 5 SW, 6 W, 7 NW.
    - Step one cell per cycle from the target, counting opponent disks k.
    - Stepping past row/col 0 or 7 terminates the direction with no flips; there is no wrap-around.
    - Reaching an empty cell terminates the direction with no flips.
    - Reaching an own disk with k >= 1 goes to FLIP. An own disk with k = 0 means no flips in that direction.
  - FLIP: re-walk from the target, nearest cell first.
    - Each of the k cells is written to the mover's colour and offered on the update port.
    - The board write occurs on the accept cycle.
    - total += k.
  - NEXT: dir 7 done -> PLACE if total > 0, else DONE with move_valid = 0. Otherwise increment dir and go to SCAN.
  - PLACE: write the target cell and offer it as the final update. On accept: move_valid = 1, flip_count = total, go to DONE.
  - DONE: pulse done for one cycle, deassert busy, return to IDLE.
- Update handshake:
  - An update transfers when upd_valid && upd_ready on a rising clk edge.
  - While upd_valid = 1 and upd_ready = 0, upd_col, upd_row and upd_cell are held stable.
  - upd_valid never drops without a transfer, except on reset.
  - After each transfer upd_valid stays low for FLIP_GAP cycles.
- An invalid move leaves the board unchanged and emits no updates.
- rd_cell reflects a board write starting from the cycle after the write.

Optional Feature:
COUNT_EN:
- Defined: black_count and white_count are incremental counters.
  - The mover's count increments per flip and for the placed disk.
  - The opponent's count decrements per flip.
  - Counts update on each accepted update; reset value is 2/2.
- Undefined: both outputs are tied to 0 and the counter logic is absent.

Test Plan:
- Reset, then read all 64 cells via rd -> only (3,3)=10, (4,4)=10, (3,4)=01, (4,3)=01 are non-empty; counts 2/2.
- Black place (3,2), upd_ready held 1 -> updates (3,3)->01 then (3,2)->01; done with move_valid=1, flip_count=1; counts 4/1.
- Black place (0,0) -> no upd_valid, done with move_valid=0, flip_count=0; board unchanged. Place on occupied (3,3) -> same invalid result.
- Black (3,2) with upd_ready low for 5 cycles on the first offer -> upd_col=3, upd_row=3, upd_cell=01 stable throughout. FLIP_GAP=2 -> exactly 2 low cycles between offers.
- Second place_req pulsed while busy -> ignored: exactly one done pulse, and only the first move is applied.
- Reset asserted while upd_valid=1 in FLIP -> next cycle: busy=0, upd_valid=0, board equals the reset pattern.
